// File: rtl/lvds_host.sv
// Host end of the two-wire LVDS remote-IO link: 56-bit command frames out as 2-bit DDR words,
// 32-bit reply frames back in, one transaction outstanding, with a reply timeout.
module lvds_host #(
  parameter bit          TINV    = 1'b0,
  parameter bit          RINV    = 1'b0,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [55:0] cmd_data_i,
  output logic [1:0]  tx_d_o,
  input  logic [1:0]  rx_d_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_timeout_o
);

  localparam logic [1:0]  IDLE_WORD = {2{~TINV}};
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

  state_t      state_q;
  logic [57:0] tx_sr_q;
  logic [4:0]  word_cnt_q;
  logic [15:0] wait_cnt_q;
  logic [30:0] rx_sr_q;
  logic        phase_b_q;
  logic        cmd_ready_q;
  logic [1:0]  tx_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_timeout_q;

  logic [1:0]  rx_word_d;
  logic [32:0] rx_full_d;
  logic [31:0] rx_data_d;

  // rx_full_d is s[1..33] once the 17th word is on the pins; the phase picks the 32-bit window.
  assign rx_word_d = rx_d_i ^ {2{RINV}};
  assign rx_full_d = {rx_sr_q, rx_word_d[0], rx_word_d[1]};
  assign rx_data_d = phase_b_q ? rx_full_d[31:0] : rx_full_d[32:1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      tx_sr_q       <= '0;
      word_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      rx_sr_q       <= '0;
      phase_b_q     <= 1'b0;
      cmd_ready_q   <= 1'b0;
      tx_q          <= IDLE_WORD;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      tx_q          <= IDLE_WORD;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            // Time-ordered frame kept MSB-first: start 0, payload MSB..LSB, pad 1.
            tx_sr_q     <= {1'b0, cmd_data_i, 1'b1};
            word_cnt_q  <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= SEND;
          end
        end
        SEND: begin
          tx_q       <= {tx_sr_q[56], tx_sr_q[57]} ^ {2{TINV}};
          tx_sr_q    <= tx_sr_q << 2;
          word_cnt_q <= word_cnt_q + 5'd1;
          if (word_cnt_q == 5'd28) begin
            wait_cnt_q <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (rx_word_d != 2'b11) begin
            phase_b_q  <= rx_word_d[0];
            rx_sr_q    <= {rx_sr_q[28:0], rx_word_d[0], rx_word_d[1]};
            word_cnt_q <= 5'd1;
            state_q    <= RECV;
          end else if (wait_cnt_q == WAIT_LAST) begin
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_data_q    <= '1;
            state_q       <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        RECV: begin
          rx_sr_q    <= {rx_sr_q[28:0], rx_word_d[0], rx_word_d[1]};
          word_cnt_q <= word_cnt_q + 5'd1;
          if (word_cnt_q == 5'd16) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rx_data_d;
            state_q     <= DONE;
          end
        end
        DONE: begin
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign tx_d_o        = tx_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule
